// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the clock period meter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_meas_pkg;

  // Default counter width and timeout, used as module parameter defaults.
  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned TIMEOUT_DEF = 1000;

  // Measurement FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TIMEOUT = 2'd2
  } meas_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Latency: 2 clk_i cycles from the first sampling edge to q_o.
// Backpressure: none, free-running.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // First stage may go metastable; second stage gives it a full cycle to settle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous clock-like signal.
// Latency: ticks 3 cycles after sampling; result valid the cycle after rise_tick.
// Backpressure: held result is kept while !meas_ready; a newer result is dropped with an overflow pulse.
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             timeout,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);

  // ------------------------------------------------------------------
  // Input synchronization and edge detection
  // ------------------------------------------------------------------
  logic sig_sync;

  sync_2ff u_sync (
    .clk_i  (clk_in),
    .rst_ni (rst_n),
    .d_i    (sig_in),
    .q_o    (sig_sync)
  );

  logic sig_prev_q;
  logic rise_q;
  logic fall_q;

  // Edge register plus registered single-cycle ticks.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sig_prev_q <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      sig_prev_q <= sig_sync;
      rise_q     <= sig_sync & ~sig_prev_q;
      fall_q     <= ~sig_sync & sig_prev_q;
    end
  end

  assign rise_tick = rise_q;
  assign fall_tick = fall_q;

  // ------------------------------------------------------------------
  // Measurement FSM
  // ------------------------------------------------------------------
  meas_state_e      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] high_cap_q, high_cap_d;
  logic             fell_q, fell_d;
  logic             cand_vld;
  logic [CNT_W-1:0] count_inc;

  // Saturating increment so a stuck-high count is recognisable as invalid.
  assign count_inc = (count_q == CNT_MAX) ? count_q : (count_q + CNT_ONE);

  // The rise_tick cycle itself is cycle 0 of the new period, so the count
  // register reads 1 in the following cycle; the value it holds during the
  // next rise_tick cycle is therefore the full period length.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    high_cap_d = high_cap_q;
    fell_d     = fell_q;
    cand_vld   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (rise_q) begin
          state_d = ST_MEASURE;
          count_d = CNT_ONE;
          fell_d  = 1'b0;
        end
      end
      ST_MEASURE: begin
        if (rise_q) begin
          // Only a complete, unsaturated period with a seen fall is reported.
          cand_vld = fell_q && (count_q != CNT_MAX);
          count_d  = CNT_ONE;
          fell_d   = 1'b0;
        end else if (count_q >= TO_LIM) begin
          state_d = ST_TIMEOUT;
          count_d = '0;
        end else begin
          count_d = count_inc;
          if (fall_q) begin
            high_cap_d = count_q;
            fell_d     = 1'b1;
          end
        end
      end
      ST_TIMEOUT: begin
        count_d = '0;
        if (rise_q) begin
          state_d = ST_MEASURE;
          count_d = CNT_ONE;
          fell_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
        fell_d  = 1'b0;
      end
    endcase
  end

  // FSM state, running count and captured high time.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      high_cap_q <= '0;
      fell_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      high_cap_q <= high_cap_d;
      fell_q     <= fell_d;
    end
  end

  // ------------------------------------------------------------------
  // Result holding register with valid/ready handshake
  // ------------------------------------------------------------------
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             timeout_q;

  // A new result may replace the held one only if the slot is empty or being
  // consumed this very cycle; otherwise the new one is dropped and flagged.
  always_comb begin
    period_d = period_q;
    high_d   = high_q;
    valid_d  = valid_q;
    ovf_d    = 1'b0;
    if (cand_vld) begin
      if (!valid_q || meas_ready) begin
        period_d = count_q;
        high_d   = high_cap_q;
        valid_d  = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && meas_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output registers; timeout mirrors the registered FSM state.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      timeout_q <= (state_d == ST_TIMEOUT);
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = valid_q;
  assign overflow   = ovf_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: waveform driver with a cycle-time
// reference model feeding an expectation queue, and a decoupled monitor.
// Latency/backpressure scenarios are driven as directed sequences.
module tb_clk_period_meter;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1000;
  localparam int LAT     = 3;

  logic             clk_in = 1'b0;
  logic             rst_n = 1'b0;
  logic             sig_in = 1'b0;
  logic             meas_ready = 1'b0;
  logic             rise_tick, fall_tick, meas_valid, timeout, overflow;
  logic [CNT_W-1:0] period, high_time;

  clk_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .rise_tick  (rise_tick),
    .fall_tick  (fall_tick),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .timeout    (timeout),
    .overflow   (overflow)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (cycle times of sig_in edges) ----------
  int q_per[$];
  int q_hi[$];
  bit armed = 0;
  bit fell = 0;
  int last_rise = 0;
  int last_fall = 0;
  int exp_ovf = 0;
  int drv_rise_cyc = -100;
  int drv_fall_cyc = -100;

  // Raise sig_in; the period ending here is the time since the previous rise.
  task automatic sig_rise(input bit drop);
    int gap;
    gap = cyc - last_rise;
    if (armed && fell && gap <= TIMEOUT && gap < (1 << CNT_W) - 1) begin
      if (drop) exp_ovf++;
      else begin
        q_per.push_back(gap);
        q_hi.push_back(last_fall - last_rise);
      end
    end
    armed = 1;
    fell = 0;
    last_rise = cyc;
    drv_rise_cyc = cyc;
    sig_in = 1'b1;
  endtask

  task automatic sig_fall();
    if (armed) begin
      fell = 1;
      last_fall = cyc;
    end
    drv_fall_cyc = cyc;
    sig_in = 1'b0;
  endtask

  task automatic model_reset();
    armed = 0;
    fell = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic pulse(input int hi, input int lo, input bit drop);
    sig_rise(drop);
    step(hi);
    sig_fall();
    step(lo);
  endtask

  // ---------------- monitor ----------------
  int ovf_seen = 0;
  int valid_cycles = 0;
  int last_tick_cyc = 0;
  int to_delta = -1;

  initial begin
    bit p_rise, p_fall, p_ovf, p_to, p_hold;
    logic [CNT_W-1:0] p_per, p_hi;
    int ep, eh;
    p_rise = 0; p_fall = 0; p_ovf = 0; p_to = 0; p_hold = 0;
    p_per = '0; p_hi = '0;
    forever begin
      @(negedge clk_in);
      if (!rst_n) begin
        p_rise = 0; p_fall = 0; p_ovf = 0; p_to = 0; p_hold = 0;
      end else begin
        if (p_hold) begin
          check("held_period", period, p_per);
          check("held_high_time", high_time, p_hi);
        end
        if (meas_valid && meas_ready) begin
          if (q_per.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_meas: got period %0d high %0d, expected no result (cycle %0d)",
                     period, high_time, cyc);
          end else begin
            ep = q_per.pop_front();
            eh = q_hi.pop_front();
            check("period", period, ep);
            check("high_time", high_time, eh);
          end
        end
        if (rise_tick) begin
          check("rise_latency", cyc - drv_rise_cyc, LAT);
          last_tick_cyc = cyc;
        end
        if (fall_tick) check("fall_latency", cyc - drv_fall_cyc, LAT);
        if (p_rise) check("rise_tick_width", rise_tick, 0);
        if (p_fall) check("fall_tick_width", fall_tick, 0);
        if (p_ovf)  check("overflow_width", overflow, 0);
        if (overflow) ovf_seen++;
        if (meas_valid) valid_cycles++;
        if (timeout && !p_to) to_delta = cyc - last_tick_cyc;
        if (!timeout && p_to) check("timeout_clear_delay", cyc - last_tick_cyc, 1);
        p_rise = rise_tick;
        p_fall = fall_tick;
        p_ovf  = overflow;
        p_to   = timeout;
        p_hold = meas_valid && !meas_ready;
        p_per  = period;
        p_hi   = high_time;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic check_all_zero(input string tag);
    check({tag, "_rise_tick"}, rise_tick, 0);
    check({tag, "_fall_tick"}, fall_tick, 0);
    check({tag, "_period"}, period, 0);
    check({tag, "_high_time"}, high_time, 0);
    check({tag, "_meas_valid"}, meas_valid, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    int v0, o0;
    bit seen;
    int hi, lo;

    // Reset state
    step(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    step(3);

    // Divide-by-10, 50% duty: results from the second rise on, one valid per period
    meas_ready = 1'b1;
    v0 = valid_cycles;
    repeat (6) pulse(5, 5, 0);
    check("valid_cycles_div10", valid_cycles - v0, 5);

    // Randomized periods and duty cycles
    repeat (40) begin
      hi = $urandom_range(2, 30);
      lo = $urandom_range(2, 30);
      pulse(hi, lo, 0);
    end

    // Backpressure across two rises: first result held, second dropped
    pulse(5, 5, 0);
    pulse(5, 5, 0);
    meas_ready = 1'b0;
    o0 = ovf_seen;
    pulse(6, 6, 0);
    pulse(7, 7, 1);
    check("ovf_pulses_on_drop", ovf_seen - o0, 1);
    check("held_valid", meas_valid, 1);
    check("held_first_period", period, 10);
    meas_ready = 1'b1;
    step(2);
    check("drained_after_ready", meas_valid, 0);
    pulse(5, 5, 0);
    pulse(5, 5, 0);

    // Load in the same cycle as a handshake
    meas_ready = 1'b0;
    o0 = ovf_seen;
    pulse(4, 7, 0);
    sig_rise(0);
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      step(1);
      if (rise_tick) seen = 1;
    end
    check("same_cycle_tick_seen", seen, 1);
    meas_ready = 1'b1;
    step(1);
    check("same_cycle_valid_kept", meas_valid, 1);
    check("same_cycle_new_period", period, 11);
    check("same_cycle_new_high", high_time, 4);
    check("same_cycle_no_overflow", ovf_seen - o0, 0);
    sig_fall();
    step(7);
    pulse(5, 5, 0);

    // Timeout: hold low after lock, then recover
    pulse(5, 5, 0);
    to_delta = -1;
    pulse(5, 1100, 0);
    check("timeout_delay", to_delta, TIMEOUT + 1);
    check("timeout_level", timeout, 1);
    pulse(5, 5, 0);
    check("timeout_cleared", timeout, 0);
    pulse(5, 5, 0);
    pulse(5, 5, 0);

    // Reset mid-period
    sig_rise(0);
    step(4);
    sig_fall();
    step(3);
    check("pre_reset_period_nonzero", (period != 0), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    step(3);
    model_reset();
    rst_n = 1'b1;
    step(2);
    v0 = valid_cycles;
    pulse(6, 6, 0);
    check("no_meas_first_rise_after_reset", valid_cycles - v0, 0);
    pulse(6, 6, 0);
    pulse(6, 6, 0);

    // Drain and final accounting
    for (int k = 0; k < 50 && q_per.size() != 0; k++) step(1);
    check("queue_drained", q_per.size(), 0);
    check("overflow_count", ovf_seen, exp_ovf);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_period_meter.md
CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 Parameter CNT_W, default 16, width of period, high-time and timeout counters.
REQ-002 Parameter TIMEOUT, default 1000, clk_in cycles without a rising edge before the timeout state; legal range 2..2^CNT_W-1.
REQ-003 clk_in  input  1  sole clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sig_in  input  1  slow clock-like signal (e.g. a divided clock), asynchronous to clk_in.
REQ-006 rise_tick  output  1  one-cycle pulse per synchronized rising edge of sig_in.
REQ-007 fall_tick  output  1  one-cycle pulse per synchronized falling edge of sig_in.
REQ-008 period  output  CNT_W  clk_in cycles between the last two rise_ticks; valid while meas_valid.
REQ-009 high_time  output  CNT_W  clk_in cycles from rise_tick to the following fall_tick within the same period.
REQ-010 meas_valid  output  1  measurement available.
REQ-011 meas_ready  input  1  consumer accepts measurement when meas_valid && meas_ready.
REQ-012 timeout  output  1  level; high while in TIMEOUT state.
REQ-013 overflow  output  1  one-cycle pulse when a new measurement is dropped.

Function
REQ-014 sig_in passes a 2-flop synchronizer then one edge-detect register; rise_tick/fall_tick assert exactly 3 clk_in cycles after the first clk_in edge sampling the new sig_in level.
REQ-015 FSM states: IDLE, MEASURE, TIMEOUT; reset state IDLE.
REQ-016 IDLE: count cleared; first rise_tick -> MEASURE, no measurement produced.
REQ-017 MEASURE: count increments each cycle, saturating at 2^CNT_W-1; cycle of rise_tick counts as 0.
REQ-018 On fall_tick in MEASURE, high_cap = count.
REQ-019 On rise_tick in MEASURE, period candidate = count, high candidate = high_cap; count restarts at 0 in that cycle.
REQ-020 A candidate whose period is saturated or with no fall_tick since last rise is discarded (no valid, no overflow).
REQ-021 MEASURE -> TIMEOUT when count reaches TIMEOUT without rise_tick; timeout=1 from the next cycle.
REQ-022 TIMEOUT: first rise_tick -> MEASURE, count restarts, no measurement, timeout=0 next cycle.
REQ-023 Accepted candidate loads period/high_time and sets meas_valid the cycle after rise_tick; outputs stable while meas_valid && !meas_ready.
REQ-024 Load with meas_valid=1 and meas_ready=0: candidate dropped, overflow pulses, held data unchanged.
REQ-025 Load in the same cycle as meas_valid && meas_ready: new data loaded, meas_valid stays 1, no overflow.
REQ-026 Handshake with no load: meas_valid clears next cycle.

Reset
REQ-027 rst_n low asynchronously clears synchronizer, edge register, count, high_cap, period, high_time, meas_valid, rise_tick, fall_tick, timeout, overflow to 0 and FSM to IDLE.
REQ-028 Reset mid-measurement discards partial data; first rise_tick after release produces no measurement.

Structure
REQ-029 Package clk_meas_pkg holds the FSM state type (IDLE, MEASURE, TIMEOUT) and default CNT_W/TIMEOUT constants.
REQ-030 Synchronizer is sub-module sync_2ff (1-bit, async active-low reset); remainder flat in clk_period_meter.

Verification
REQ-031 sig_in = clk_in/10, 50% duty, meas_ready=1 -> from second rise on, period=10, high_time=5, meas_valid one cycle per 10.
REQ-032 sig_in toggle -> rise_tick exactly 3 cycles after sampling edge; single-cycle pulses only.
REQ-033 sig_in held low after lock, TIMEOUT=1000 -> timeout=1 1001 cycles after last rise_tick; next rise clears it, no measurement; following rise gives correct period.
REQ-034 meas_ready=0 across two rises -> first result held, overflow pulse on second; ready=1 then yields first result only.
REQ-035 Load and handshake in same cycle -> new period visible, meas_valid continuous, overflow=0.
REQ-036 rst_n asserted mid-period -> all outputs 0 immediately; after release first rise gives no meas_valid, second gives correct period.
